// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM arbiter: command encodings and the sequencer state type.
package sdram_arb_pkg;

  localparam logic [1:0] CMD_NOP     = 2'b00;
  localparam logic [1:0] CMD_READ    = 2'b01;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_REFRESH = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    REFRESH,
    VGA_RUN,
    CPU_RUN,
    CPU_DONE
  } arb_state_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval timer; expire pulses for one cycle every REFRESH_PERIOD cycles.
module sdram_refresh_timer #(
  parameter int unsigned REFRESH_PERIOD = 750
) (
  input  logic clk,
  input  logic rst_n,
  output logic expire
);

  localparam int unsigned   CW     = $clog2(REFRESH_PERIOD + 1);
  localparam logic [CW-1:0] RELOAD = CW'(REFRESH_PERIOD - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RELOAD;
    end else if (count == '0) begin
      count <= RELOAD;
    end else begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM command engine between refresh, VGA prefetch bursts and CPU byte accesses.
// Define SDRAM_ARB_FAIR_EN to give the CPU one turn after each VGA burst it waited through.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned REFRESH_PERIOD = 750,
  parameter int unsigned VGA_BURST      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [23:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  input  logic        vga_req,
  input  logic [22:0] vga_addr,
  output logic        vga_ack,
  output logic [15:0] vga_data,
  output logic        vga_valid,
  output logic        vga_last,
  output logic [1:0]  mem_cmd,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic        mem_start,
  input  logic        mem_busy,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        refresh_miss
);

  localparam logic [8:0] LAST_WORD = 9'(VGA_BURST - 1);

  arb_state_t  state, next;
  logic        expire;
  logic        ref_pend;
  logic        issued;
  logic        cpu_fin;
  logic [22:0] vga_ptr;
  logic [8:0]  word_cnt;
  logic        refresh_clear;
  logic        burst_end;

  assign refresh_clear = (state == REFRESH) && mem_done;
  assign burst_end     = (state == VGA_RUN) && mem_done && (word_cnt == LAST_WORD);

  sdram_refresh_timer #(
    .REFRESH_PERIOD(REFRESH_PERIOD)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .expire(expire)
  );

`ifdef SDRAM_ARB_FAIR_EN
  logic cpu_owed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_owed <= 1'b0;
    end else if (burst_end && cpu_req) begin
      cpu_owed <= 1'b1;
    end else if (state == IDLE && next == CPU_RUN) begin
      cpu_owed <= 1'b0;
    end
  end
`endif

  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (ref_pend) next = REFRESH;
`ifdef SDRAM_ARB_FAIR_EN
        else if (cpu_owed && cpu_req) next = CPU_RUN;
`endif
        else if (vga_req) next = VGA_RUN;
        else if (cpu_req) next = CPU_RUN;
      end
      REFRESH:  if (mem_done)  next = IDLE;
      VGA_RUN:  if (burst_end) next = IDLE;
      CPU_RUN:  if (cpu_fin)   next = CPU_DONE;
      CPU_DONE: next = IDLE;
      default:  next = IDLE;
    endcase
  end

  // Command fields are only driven in the issuing states; mem_cmd is NOP unless strobed.
  always_comb begin
    mem_start = 1'b0;
    mem_cmd   = CMD_NOP;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    vga_ack   = (state == IDLE) && (next == VGA_RUN);
    cpu_ready = (state == CPU_DONE);
    case (state)
      REFRESH: begin
        mem_start = !issued && !mem_busy;
        if (mem_start) mem_cmd = CMD_REFRESH;
      end
      VGA_RUN: begin
        mem_start = !issued && !mem_busy;
        mem_addr  = vga_ptr;
        mem_be    = 2'b11;
        if (mem_start) mem_cmd = CMD_READ;
      end
      CPU_RUN: begin
        mem_start = !issued && !mem_busy;
        mem_addr  = cpu_addr[23:1];
        mem_be    = cpu_addr[0] ? 2'b10 : 2'b01;
        mem_wdata = {cpu_wdata, cpu_wdata};
        if (mem_start) mem_cmd = cpu_we ? CMD_WRITE : CMD_READ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ref_pend     <= 1'b0;
      refresh_miss <= 1'b0;
      issued       <= 1'b0;
      cpu_fin      <= 1'b0;
      vga_ptr      <= '0;
      word_cnt     <= '0;
      cpu_rdata    <= '0;
      vga_data     <= '0;
      vga_valid    <= 1'b0;
      vga_last     <= 1'b0;
    end else begin
      state     <= next;
      vga_valid <= 1'b0;
      vga_last  <= 1'b0;

      // A new expiry outranks the clear from a completing refresh.
      if (expire) ref_pend <= 1'b1;
      else if (refresh_clear) ref_pend <= 1'b0;
      if (expire && ref_pend && !refresh_clear) refresh_miss <= 1'b1;

      if (mem_start) issued <= 1'b1;
      if (state != next) issued <= 1'b0;

      case (state)
        IDLE: begin
          if (next == VGA_RUN) begin
            vga_ptr  <= vga_addr;
            word_cnt <= '0;
          end
        end
        VGA_RUN: begin
          if (mem_done) begin
            issued    <= 1'b0;
            vga_valid <= 1'b1;
            vga_data  <= mem_rdata;
            vga_last  <= (word_cnt == LAST_WORD);
            word_cnt  <= word_cnt + 1'b1;
            vga_ptr   <= vga_ptr + 1'b1;
          end
        end
        CPU_RUN: begin
          if (mem_done) begin
            cpu_fin <= 1'b1;
            if (!cpu_we) cpu_rdata <= cpu_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];
          end
        end
        CPU_DONE: cpu_fin <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter with a small command-engine model (latency set per test).
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  localparam int unsigned PERIOD = 20;
  localparam int unsigned BURST  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [23:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        vga_req, vga_ack, vga_valid, vga_last;
  logic [22:0] vga_addr;
  logic [15:0] vga_data;
  logic [1:0]  mem_cmd, mem_be;
  logic [22:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_start, mem_busy, mem_done, refresh_miss;
  logic        outs_any;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .REFRESH_PERIOD(PERIOD),
    .VGA_BURST     (BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack), .vga_data(vga_data),
    .vga_valid(vga_valid), .vga_last(vga_last),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_start(mem_start), .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .refresh_miss(refresh_miss)
  );

  assign outs_any = |{cpu_rdata, cpu_ready, vga_ack, vga_data, vga_valid, vga_last,
                      mem_cmd, mem_addr, mem_wdata, mem_be, mem_start, refresh_miss};

  typedef struct packed {logic [1:0] cmd; logic [22:0] addr; logic [1:0] be; logic [15:0] wdata;} cmd_t;
  typedef struct packed {logic last; logic [15:0] data;} vga_t;
  typedef struct packed {logic rd; logic [7:0] data;} cpu_t;

  cmd_t cmd_q[$];
  vga_t vga_q[$];
  cpu_t cpu_q[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, done_cyc = 0, last_ref_cyc = 0;
  int n_ref = 0, n_ack = 0, n_valid = 0, n_ready = 0;
  int lat = 0;
  bit sb_on = 1'b1, chk_ref = 1'b0, ref_seen = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [22:0] a);
    return a[15:0] ^ 16'h1235;
  endfunction

  // Command engine model: done arrives lat+1 cycles after the strobe.
  int          eng_cnt;
  logic [22:0] eng_addr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_cnt   <= 0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_done <= 1'b0;
      if (mem_start) begin
        if (lat == 0) begin
          mem_done  <= 1'b1;
          mem_rdata <= word_of(mem_addr);
        end else begin
          eng_cnt  <= lat;
          eng_addr <= mem_addr;
        end
      end else if (eng_cnt != 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) begin
          mem_done  <= 1'b1;
          mem_rdata <= word_of(eng_addr);
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    cmd_t ec;
    vga_t ev;
    cpu_t eu;
    if (rst_n) begin
      if (mem_start) begin
        if (mem_cmd == CMD_REFRESH) begin
          if (chk_ref && ref_seen) check("ref_interval", 64'(cyc - last_ref_cyc), 64'(PERIOD));
          ref_seen     = 1'b1;
          last_ref_cyc = cyc;
          n_ref++;
        end else if (sb_on) begin
          if (cmd_q.size() == 0) check("cmd_unexpected", 64'(cmd_q.size()), 64'd1);
          else begin
            ec = cmd_q.pop_front();
            check("cmd", 64'(cmd_t'{mem_cmd, mem_addr, mem_be, mem_wdata}), 64'(ec));
          end
        end
      end
      if (vga_valid) begin
        n_valid++;
        check("vga_latency", 64'(cyc - done_cyc), 64'd1);
        if (sb_on) begin
          if (vga_q.size() == 0) check("vga_unexpected", 64'(vga_q.size()), 64'd1);
          else begin
            ev = vga_q.pop_front();
            check("vga_word", 64'(vga_t'{vga_last, vga_data}), 64'(ev));
          end
        end
      end
      if (cpu_ready) begin
        n_ready++;
        check("cpu_latency", 64'(cyc - done_cyc), 64'd2);
        if (cpu_q.size() == 0) check("cpu_unexpected", 64'(cpu_q.size()), 64'd1);
        else begin
          eu = cpu_q.pop_front();
          if (eu.rd) check("cpu_rdata", 64'(cpu_rdata), 64'(eu.data));
        end
      end
      if (vga_ack) n_ack++;
      if (mem_done) done_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag, input int budget, input int s);
    for (int i = 0; i < budget && n_ready == s; i++) tick(1);
    check(tag, 64'(n_ready - s), 64'd1);
  endtask

  task automatic wait_ack(input string tag, input int budget, input int s);
    for (int i = 0; i < budget && n_ack == s; i++) tick(1);
    check(tag, 64'(n_ack - s), 64'd1);
  endtask

  task automatic cpu_access(input logic [23:0] a, input logic we, input logic [7:0] wd);
    logic [15:0] w;
    int s;
    s = n_ready;
    w = word_of(a[23:1]);
    cmd_q.push_back(cmd_t'{we ? CMD_WRITE : CMD_READ, a[23:1], a[0] ? 2'b10 : 2'b01, {wd, wd}});
    cpu_q.push_back(cpu_t'{!we, a[0] ? w[15:8] : w[7:0]});
    cpu_req = 1'b1; cpu_addr = a; cpu_we = we; cpu_wdata = wd;
    wait_ready("cpu_done", 100, s);
    cpu_req = 1'b0;
  endtask

  task automatic vga_burst(input logic [22:0] base);
    logic [22:0] a;
    int sa, sv;
    sa = n_ack;
    sv = n_valid;
    for (int unsigned i = 0; i < BURST; i++) begin
      a = base + 23'(i);
      cmd_q.push_back(cmd_t'{CMD_READ, a, 2'b11, 16'h0000});
      vga_q.push_back(vga_t'{(i == BURST - 1), word_of(a)});
    end
    vga_req = 1'b1; vga_addr = base;
    wait_ack("vga_ack_seen", 50, sa);
    vga_req = 1'b0;
    for (int i = 0; i < 200 && (n_valid - sv) < int'(BURST); i++) tick(1);
    check("vga_word_count", 64'(n_valid - sv), 64'(BURST));
    tick(3);
    check("vga_ack_count", 64'(n_ack - sa), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, sv, sa;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0; mem_busy = 1'b0; lat = 0;
    tick(3);
    check("reset_outputs", 64'(outs_any), 64'd0);
    rst_n = 1'b1;

    lat = 3;
    cpu_access(24'h000003, 1'b1, 8'hA5);
    lat = 0;
    cpu_access(24'h000002, 1'b0, 8'h00);
    cpu_access(24'h000101, 1'b0, 8'h00);
    vga_burst(23'h7FFFFE);
    check("cmd_queue_drained", 64'(cmd_q.size()), 64'd0);
    check("vga_queue_drained", 64'(vga_q.size()), 64'd0);

    // Reset in the middle of a burst
    sb_on = 1'b0;
    sa = n_ack;
    sv = n_valid;
    vga_req = 1'b1; vga_addr = 23'h000040;
    wait_ack("midburst_ack", 50, sa);
    vga_req = 1'b0;
    tick(5);
    check("midburst_words_seen", 64'((n_valid - sv) > 0 && (n_valid - sv) < int'(BURST)), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midburst_reset_outputs", 64'(outs_any), 64'd0);
    tick(2);
    cmd_q.delete(); vga_q.delete();
    rst_n = 1'b1;
    sb_on = 1'b1;

    // Idle bus refresh cadence
    ref_seen = 1'b0; chk_ref = 1'b1;
    s = n_ref;
    tick(70);
    chk_ref = 1'b0;
    check("refresh_count", 64'(n_ref - s), 64'd3);
    check("miss_idle", 64'(refresh_miss), 64'd0);

    // Engine stalled: refresh overruns
    mem_busy = 1'b1;
    tick(50);
    check("miss_set", 64'(refresh_miss), 64'd1);
    mem_busy = 1'b0;
    s = n_ref;
    tick(30);
    check("miss_sticky", 64'(refresh_miss), 64'd1);
    check("refresh_after_stall", 64'(n_ref > s), 64'd1);
    rst_n = 1'b0;
    tick(2);
    check("miss_cleared", 64'(refresh_miss), 64'd0);
    rst_n = 1'b1;

    // Continuous VGA demand with a waiting CPU
    sb_on = 1'b0;
    cpu_q.push_back(cpu_t'{1'b0, 8'h00});
    s = n_ready;
    sa = n_ack;
    vga_addr = 23'h000100; vga_req = 1'b1;
    cpu_addr = 24'h000005; cpu_we = 1'b1; cpu_wdata = 8'h3C; cpu_req = 1'b1;
`ifdef SDRAM_ARB_FAIR_EN
    wait_ready("fair_cpu_done", 80, s);
    check("fair_bursts_before_cpu", 64'(n_ack - sa), 64'd1);
    cpu_req = 1'b0;
    vga_req = 1'b0;
`else
    tick(120);
    check("strict_cpu_starved", 64'(n_ready - s), 64'd0);
    vga_req = 1'b0;
    wait_ready("strict_cpu_after_vga", 60, s);
    cpu_req = 1'b0;
`endif
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
